// File: rtl/seven_seg_pkg.sv
// Shared definitions for the two-digit seven-segment display path.
// Used by the display arbiter, the display mux and segment encoders.
package seven_seg_pkg;

    localparam int SEG_W  = 7;
    localparam int DISP_W = 2 * SEG_W;

    localparam logic [DISP_W-1:0] BLANK_PATTERN = '0;

    typedef enum logic [1:0] {
        IDLE,
        OWN,
        SWITCH
    } arb_state_e;

    function automatic logic [DISP_W-1:0] join_digits(
        input logic [SEG_W-1:0] hi,
        input logic [SEG_W-1:0] lo
    );
        return {hi, lo};
    endfunction

endpackage

// File: rtl/seven_seg_display_arbiter_if.sv
// Request/grant and segment bus between display requesters and the arbiter.
// Requesters drive the master side; the arbiter is the slave.
interface seven_seg_display_arbiter_if #(
    parameter int N_REQ = 4
);
    import seven_seg_pkg::*;

    logic [N_REQ-1:0]        req;
    logic [N_REQ*DISP_W-1:0] disp_data;
    logic                    tick;
    logic [N_REQ-1:0]        gnt;
    logic [DISP_W-1:0]       both7seg;
    logic                    busy;

    modport master (
        output req,
        output disp_data,
        output tick,
        input  gnt,
        input  both7seg,
        input  busy
    );

    modport slave (
        input  req,
        input  disp_data,
        input  tick,
        output gnt,
        output both7seg,
        output busy
    );

endinterface

// File: rtl/seven_seg_rr_pick.sv
// Combinational round-robin picker: first set req bit after ptr, with wrap.
// Returns a one-hot pick and a valid flag.
module seven_seg_rr_pick #(
    parameter int N  = 4,
    parameter int PW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  pick,
    output logic          valid
);

    always_comb begin
        pick  = '0;
        valid = 1'b0;
        for (int k = 1; k <= N; k++) begin
            if (!valid && req[(int'(ptr) + k) % N]) begin
                pick[(int'(ptr) + k) % N] = 1'b1;
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/seven_seg_display_arbiter.sv
// Round-robin owner of the shared seven-segment display with refresh-based hold limit.
// Optional SEVEN_SEG_ARB_PRIO0_EN makes requester 0 urgent.
module seven_seg_display_arbiter
    import seven_seg_pkg::*;
#(
    parameter int                N_REQ        = 4,
    parameter int                MAX_HOLD     = 3,
    parameter logic [DISP_W-1:0] IDLE_PATTERN = BLANK_PATTERN
) (
    input logic                         clk,
    input logic                         rst,
    seven_seg_display_arbiter_if.slave  bus
);

    localparam int PW = $clog2(N_REQ);
    localparam int HW = $clog2(MAX_HOLD + 1);
    localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD);

    arb_state_e        state, state_n;
    logic [PW-1:0]     ptr, ptr_n;
    logic [PW-1:0]     owner, owner_n;
    logic [HW-1:0]     hold, hold_n;
    logic [N_REQ-1:0]  gnt_q, gnt_n;
    logic [DISP_W-1:0] seg_q, seg_n;

    logic [N_REQ-1:0]  rr_oh, pick_oh;
    logic              rr_vld, pick_vld;
    logic [PW-1:0]     pick_idx;
    logic [DISP_W-1:0] own_data;
    logic              release_c, rotate, urgent, keep_ptr;

    seven_seg_rr_pick #(
        .N  (N_REQ),
        .PW (PW)
    ) u_pick (
        .req   (bus.req),
        .ptr   (ptr),
        .pick  (rr_oh),
        .valid (rr_vld)
    );

`ifdef SEVEN_SEG_ARB_PRIO0_EN
    // Requester 0 jumps the queue; its own turns leave ptr untouched.
    assign pick_oh  = bus.req[0] ? N_REQ'(1) : rr_oh;
    assign pick_vld = rr_vld;
    assign urgent   = bus.req[0] && (owner != '0);
    assign keep_ptr = (owner == '0);
`else
    assign pick_oh  = rr_oh;
    assign pick_vld = rr_vld;
    assign urgent   = 1'b0;
    assign keep_ptr = 1'b0;
`endif

    always_comb begin
        pick_idx = '0;
        own_data = IDLE_PATTERN;
        for (int i = 0; i < N_REQ; i++) begin
            if (pick_oh[i])
                pick_idx = PW'(i);
            if (owner == PW'(i))
                own_data = bus.disp_data[DISP_W*i +: DISP_W];
        end
    end

    assign release_c = !bus.req[owner];
    assign rotate    = (hold == HOLD_MAX) && |(bus.req & ~gnt_q);

    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        owner_n = owner;
        hold_n  = hold;
        gnt_n   = '0;
        seg_n   = IDLE_PATTERN;
        unique case (state)
            IDLE: begin
                if (pick_vld) begin
                    state_n = OWN;
                    owner_n = pick_idx;
                    hold_n  = '0;
                    gnt_n   = pick_oh;
                end
            end
            OWN: begin
                if (bus.tick && hold != HOLD_MAX)
                    hold_n = hold + 1'b1;
                if (release_c || rotate || urgent) begin
                    state_n = SWITCH;
                end else begin
                    gnt_n = gnt_q;
                    seg_n = own_data;
                end
            end
            SWITCH: begin
                state_n = IDLE;
                if (!keep_ptr)
                    ptr_n = owner;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            ptr   <= PW'(N_REQ - 1);
            owner <= '0;
            hold  <= '0;
            gnt_q <= '0;
            seg_q <= IDLE_PATTERN;
        end else begin
            state <= state_n;
            ptr   <= ptr_n;
            owner <= owner_n;
            hold  <= hold_n;
            gnt_q <= gnt_n;
            seg_q <= seg_n;
        end
    end

    assign bus.gnt      = gnt_q;
    assign bus.both7seg = seg_q;
    assign bus.busy     = (state == OWN);

endmodule
